// File: rtl/blackjack_pkg.sv
// Shared constants for the blackjack board: button channel indices and count.
package blackjack_pkg;

  localparam int unsigned BTN_RESET       = 0;
  localparam int unsigned BTN_NEXT        = 1;
  localparam int unsigned BTN_HIT         = 2;
  localparam int unsigned BTN_STAND       = 3;
  localparam int unsigned BTN_DOUBLE      = 4;
  localparam int unsigned NUM_BTN_DEFAULT = 5;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF sync, arming guard, counter debounce, registered
// press/release strobes and long-press level.
module btn_debounce_ch #(
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic held,
  output logic armed
);

  localparam int unsigned DB_W   = $clog2(DB_CYCLES);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic              sync1, sync2;
  logic              stable, stable_d, stable_nxt;
  logic              press_r, rel_r, held_r, armed_r;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  // Accepted level for the next cycle; held must drop on this same edge.
  always_comb begin
    stable_nxt = stable;
    if (armed_r && (sync2 != stable) && (db_cnt == DB_LAST))
      stable_nxt = sync2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      armed_r  <= 1'b0;
      db_cnt   <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      press_r  <= 1'b0;
      rel_r    <= 1'b0;
      hold_cnt <= '0;
      held_r   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;

      // Unarmed: wait for DB_CYCLES released samples so a button held
      // through reset never produces a spurious press.
      if (!armed_r) begin
        if (sync2)
          db_cnt <= '0;
        else if (db_cnt == DB_LAST) begin
          armed_r <= 1'b1;
          db_cnt  <= '0;
        end else
          db_cnt <= db_cnt + DB_W'(1);
      end else if (sync2 != stable)
        db_cnt <= (db_cnt == DB_LAST) ? '0 : db_cnt + DB_W'(1);
      else
        db_cnt <= '0;

      stable   <= stable_nxt;
      stable_d <= stable;
      press_r  <= stable & ~stable_d;
      rel_r    <= ~stable & stable_d;

      if (!stable)
        hold_cnt <= '0;
      else if (hold_cnt != HOLD_LAST)
        hold_cnt <= hold_cnt + HOLD_W'(1);

      held_r <= stable_nxt & (held_r | (stable & (hold_cnt == HOLD_LAST)));
    end
  end

  assign level = stable  & armed_r;
  assign press = press_r & armed_r;
  assign rel   = rel_r   & armed_r;
  assign held  = held_r  & armed_r;
  assign armed = armed_r;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the board push-buttons: one independent debounce channel per pin.
module btn_conditioner
  import blackjack_pkg::*;
#(
  parameter int unsigned NUM_BTN     = NUM_BTN_DEFAULT,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned HOLD_CYCLES = 100000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_held,
  output logic [NUM_BTN-1:0] btn_armed
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i]),
      .held (btn_held[i]),
      .armed(btn_armed[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4, HOLD_CYCLES=16.
module tb_btn_conditioner;
  import blackjack_pkg::*;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_held, btn_armed;
  logic [N-1:0] acc;
  int           checks = 0;
  int           errors = 0;

  btn_conditioner #(.NUM_BTN(N), .DB_CYCLES(4), .HOLD_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_held   (btn_held),
    .btn_armed  (btn_armed)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " level"},   btn_level,   '0);
    check({tag, " press"},   btn_press,   '0);
    check({tag, " release"}, btn_release, '0);
    check({tag, " held"},    btn_held,    '0);
    check({tag, " armed"},   btn_armed,   '0);
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = '0;
    tick(2);
    check_all_zero("reset");

    // Arming with all buttons released.
    reset = 1'b0;
    tick(10);
    check("armed_all", btn_armed, 5'b11111);
    check("idle_level", btn_level, 5'b00000);

    // Single press latency on HIT.
    btn_raw[BTN_HIT] = 1'b1;
    tick(5);
    check("hit_lvl_e5", btn_level, 5'b00000);
    tick(1);
    check("hit_lvl_e6", btn_level, 5'b00100);
    check("hit_prs_e6", btn_press, 5'b00000);
    tick(1);
    check("hit_prs_e7", btn_press, 5'b00100);
    tick(1);
    check("hit_prs_e8", btn_press, 5'b00000);
    check("hit_lvl_e8", btn_level, 5'b00100);
    btn_raw[BTN_HIT] = 1'b0;
    tick(6);
    check("hit_rel_lvl", btn_level, 5'b00000);
    check("hit_rel_e6", btn_release, 5'b00000);
    tick(1);
    check("hit_rel_e7", btn_release, 5'b00100);
    tick(1);
    check("hit_rel_e8", btn_release, 5'b00000);
    tick(4);

    // Glitches on NEXT shorter than the debounce window.
    acc = '0;
    for (int p = 0; p < 2; p++) begin
      btn_raw[BTN_NEXT] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        acc |= btn_level | btn_press | btn_release;
      end
      btn_raw[BTN_NEXT] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        acc |= btn_level | btn_press | btn_release;
      end
    end
    for (int k = 0; k < 6; k++) begin
      tick(1);
      acc |= btn_level | btn_press | btn_release;
    end
    check("glitch_quiet", acc, 5'b00000);

    // RESET button held through reset stays unarmed.
    btn_raw[BTN_RESET] = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    acc = '0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      acc |= btn_level | btn_press | btn_release | btn_held;
    end
    check("held_rst_quiet", acc, 5'b00000);
    check("held_rst_armed", btn_armed, 5'b11110);
    btn_raw[BTN_RESET] = 1'b0;
    tick(5);
    check("rearm_e5", btn_armed, 5'b11110);
    tick(1);
    check("rearm_e6", btn_armed, 5'b11111);
    btn_raw[BTN_RESET] = 1'b1;
    tick(6);
    check("rst_prs_e6", btn_press, 5'b00000);
    tick(1);
    check("rst_prs_e7", btn_press, 5'b00001);
    btn_raw[BTN_RESET] = 1'b0;
    tick(10);

    // Long press on STAND.
    btn_raw[BTN_STAND] = 1'b1;
    tick(6);
    check("stand_lvl", btn_level, 5'b01000);
    tick(15);
    check("stand_held_e21", btn_held, 5'b00000);
    tick(1);
    check("stand_held_e22", btn_held, 5'b01000);
    tick(8);
    check("stand_held_e30", btn_held, 5'b01000);
    btn_raw[BTN_STAND] = 1'b0;
    tick(5);
    check("stand_rel_e5_held", btn_held, 5'b01000);
    check("stand_rel_e5_lvl", btn_level, 5'b01000);
    tick(1);
    check("stand_rel_e6_held", btn_held, 5'b00000);
    check("stand_rel_e6_lvl", btn_level, 5'b00000);
    tick(1);
    check("stand_rel_e7", btn_release, 5'b01000);
    tick(1);
    check("stand_rel_e8", btn_release, 5'b00000);
    tick(4);

    // Simultaneous HIT and DOUBLE.
    btn_raw[BTN_HIT]    = 1'b1;
    btn_raw[BTN_DOUBLE] = 1'b1;
    tick(6);
    check("dual_prs_e6", btn_press, 5'b00000);
    tick(1);
    check("dual_prs_e7", btn_press, 5'b10100);
    tick(1);
    check("dual_prs_e8", btn_press, 5'b00000);
    btn_raw = '0;
    tick(10);

    // Reset in the middle of a debounce count.
    btn_raw[BTN_NEXT] = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(1);
    check_all_zero("mid_rst");
    reset   = 1'b0;
    btn_raw = '0;
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      acc |= btn_level | btn_press | btn_release | btn_held;
    end
    check("post_rst_quiet", acc, 5'b00000);
    check("post_rst_armed", btn_armed, 5'b11111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
